// File: rtl/select_led_driver.sv
// rtl/select_led_driver.sv - front-panel selection LED driver with change blink and PWM dimming
module select_led_driver #(
    parameter int BLINK_HALF_CYCLES = 6250000,
    parameter int BLINK_COUNT       = 3,
    parameter int PWM_BITS          = 4,
    parameter int DUTY              = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  freqSelect,
    input  logic [2:0]  lowpassSelect,
    input  logic [2:0]  highpassSelect,
    output logic [15:0] leds_n
);
    localparam int HCW = $clog2(BLINK_HALF_CYCLES + 1);
    localparam int PCW = $clog2(BLINK_COUNT + 1);
    localparam logic [HCW-1:0]    HALF_LOAD = HCW'(BLINK_HALF_CYCLES - 1);
    localparam logic [PCW-1:0]    PAIR_LOAD = PCW'(BLINK_COUNT - 1);
    localparam logic [PWM_BITS:0] DUTY_W    = (PWM_BITS + 1)'(DUTY);
    localparam logic [8:0]        SEL_RESET = {3'd0, 3'd0, 3'd5};

    typedef enum logic {IDLE, BLINK} blink_state_e;

    logic [8:0]          sync1_q, sync1_d, sync2_q, sync2_d;
    logic [2:0]          acc_q [3];
    logic [2:0]          acc_d [3];
    blink_state_e        state_q [3];
    blink_state_e        state_d [3];
    logic                phase_on_q [3];
    logic                phase_on_d [3];
    logic [HCW-1:0]      phase_cnt_q [3];
    logic [HCW-1:0]      phase_cnt_d [3];
    logic [PCW-1:0]      pair_cnt_q [3];
    logic [PCW-1:0]      pair_cnt_d [3];
    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [15:0]         leds_n_d;
    logic [2:0]          lit;
    logic                pwm_on;

    always_comb begin
        sync1_d   = {highpassSelect, lowpassSelect, freqSelect};
        sync2_d   = sync1_q;
        pwm_cnt_d = pwm_cnt_q + 1'b1;
        pwm_on    = {1'b0, pwm_cnt_q} <= DUTY_W;
        for (int g = 0; g < 3; g++) begin
            acc_d[g]       = sync2_q[3*g +: 3];
            state_d[g]     = state_q[g];
            phase_on_d[g]  = phase_on_q[g];
            phase_cnt_d[g] = phase_cnt_q[g];
            pair_cnt_d[g]  = pair_cnt_q[g];
            if (acc_d[g] != acc_q[g]) begin
                // Filter selections 4..7 are invalid and never blink
                if (g == 0 || !acc_d[g][2]) begin
                    state_d[g]     = BLINK;
                    phase_on_d[g]  = 1'b0;
                    phase_cnt_d[g] = HALF_LOAD;
                    pair_cnt_d[g]  = PAIR_LOAD;
                end else begin
                    state_d[g] = IDLE;
                end
            end else if (state_q[g] == BLINK) begin
                if (phase_cnt_q[g] == '0) begin
                    phase_cnt_d[g] = HALF_LOAD;
                    phase_on_d[g]  = !phase_on_q[g];
                    if (phase_on_q[g]) begin
                        if (pair_cnt_q[g] == '0) begin
                            state_d[g] = IDLE;
                        end else begin
                            pair_cnt_d[g] = pair_cnt_q[g] - 1'b1;
                        end
                    end
                end else begin
                    phase_cnt_d[g] = phase_cnt_q[g] - 1'b1;
                end
            end
            lit[g] = (g == 0 || !acc_q[g][2]) && (state_q[g] == IDLE || phase_on_q[g]) && pwm_on;
        end
        leds_n_d = '1;
        if (lit[0]) leds_n_d[{1'b0, acc_q[0]}] = 1'b0;
        if (lit[1]) leds_n_d[{2'b10, acc_q[1][1:0]}] = 1'b0;
        if (lit[2]) leds_n_d[{2'b11, acc_q[2][1:0]}] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q   <= SEL_RESET;
            sync2_q   <= SEL_RESET;
            pwm_cnt_q <= '0;
            leds_n    <= 16'hFFFF;
            for (int g = 0; g < 3; g++) begin
                acc_q[g]       <= SEL_RESET[3*g +: 3];
                state_q[g]     <= IDLE;
                phase_on_q[g]  <= 1'b0;
                phase_cnt_q[g] <= '0;
                pair_cnt_q[g]  <= '0;
            end
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            pwm_cnt_q <= pwm_cnt_d;
            leds_n    <= leds_n_d;
            for (int g = 0; g < 3; g++) begin
                acc_q[g]       <= acc_d[g];
                state_q[g]     <= state_d[g];
                phase_on_q[g]  <= phase_on_d[g];
                phase_cnt_q[g] <= phase_cnt_d[g];
                pair_cnt_q[g]  <= pair_cnt_d[g];
            end
        end
    end
endmodule

// File: tb/tb_select_led_driver.sv
// tb/tb_select_led_driver.sv - self-checking bench for select_led_driver
module tb_select_led_driver;
    localparam int H  = 4;
    localparam int BC = 2;
    localparam int BL = 2 * BC * H;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  freqSelect = 3'd5;
    logic [2:0]  lowpassSelect = 3'd0;
    logic [2:0]  highpassSelect = 3'd0;
    logic [15:0] leds_n, leds_n_dim;
    logic [15:0] exp_leds, exp_dim;

    int checks = 0;
    int errors = 0;

    // Reference model: accepted value, edges since blink start (-1 = steady), input history
    int m_acc [3];
    int m_age [3];
    int m_h0 [3];
    int m_h1 [3];
    int m_h2 [3];
    int m_pwm;

    always #5 clk = ~clk;

    select_led_driver #(.BLINK_HALF_CYCLES(H), .BLINK_COUNT(BC), .PWM_BITS(4), .DUTY(15)) dut (
        .clk(clk), .reset(reset), .freqSelect(freqSelect), .lowpassSelect(lowpassSelect),
        .highpassSelect(highpassSelect), .leds_n(leds_n));

    select_led_driver #(.BLINK_HALF_CYCLES(H), .BLINK_COUNT(BC), .PWM_BITS(4), .DUTY(3)) dut_dim (
        .clk(clk), .reset(reset), .freqSelect(freqSelect), .lowpassSelect(lowpassSelect),
        .highpassSelect(highpassSelect), .leds_n(leds_n_dim));

    function automatic logic [15:0] render(int duty);
        logic [15:0] r;
        int base;
        r = 16'hFFFF;
        for (int g = 0; g < 3; g++) begin
            base = (g == 0) ? 0 : (g == 1) ? 8 : 12;
            if (!(g > 0 && m_acc[g] > 3) && !(m_age[g] >= 0 && ((m_age[g] / H) % 2) == 0)
                && m_pwm <= duty)
                r[base + m_acc[g]] = 1'b0;
        end
        return r;
    endfunction

    task automatic model_reset();
        for (int g = 0; g < 3; g++) begin
            m_acc[g] = (g == 0) ? 5 : 0;
            m_h0[g] = m_acc[g];
            m_h1[g] = m_acc[g];
            m_h2[g] = m_acc[g];
            m_age[g] = -1;
        end
        m_pwm = 0;
    endtask

    task automatic step();
        int in_v [3];
        @(posedge clk);
        in_v[0] = int'(freqSelect);
        in_v[1] = int'(lowpassSelect);
        in_v[2] = int'(highpassSelect);
        exp_leds = render(15);
        exp_dim = render(3);
        m_pwm = (m_pwm + 1) % 16;
        for (int g = 0; g < 3; g++) begin
            if (m_age[g] >= 0) begin
                m_age[g]++;
                if (m_age[g] >= BL) m_age[g] = -1;
            end
            m_h2[g] = m_h1[g];
            m_h1[g] = m_h0[g];
            m_h0[g] = in_v[g];
            if (m_h2[g] != m_acc[g]) begin
                m_acc[g] = m_h2[g];
                m_age[g] = (g == 0 || m_acc[g] < 4) ? 0 : -1;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        checks++;
        if (leds_n !== 16'hFFFF || leds_n_dim !== 16'hFFFF) begin
            errors++;
            $display("FAIL reset_async got %h/%h exp ffff", leds_n, leds_n_dim);
        end
        freqSelect = 3'd5;
        lowpassSelect = 3'd0;
        highpassSelect = 3'd0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (leds_n !== 16'hFFFF) begin
            errors++;
            $display("FAIL reset_hold got %h exp ffff", leds_n);
        end
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 1; i <= 20; i++) begin
            step();
            checks++;
            if (leds_n !== 16'hEEDF) begin
                errors++;
                $display("FAIL reset_release cyc %0d got %h exp eedf", i, leds_n);
            end
        end
    endtask

    task automatic test_freq_change();
        logic [7:0] want;
        freqSelect = 3'd2;
        for (int i = 1; i <= 24; i++) begin
            step();
            if (i <= 3) want = 8'hDF;
            else if (i < 20 && ((i - 4) / 4) % 2 == 0) want = 8'hFF;
            else want = 8'hFB;
            checks++;
            if (leds_n !== exp_leds || leds_n[7:0] !== want || leds_n[15:8] !== 8'hEE) begin
                errors++;
                $display("FAIL freq_change cyc %0d got %h exp %h", i, leds_n, {8'hEE, want});
            end
        end
    endtask

    task automatic test_invalid_lowpass();
        logic [3:0] want;
        lowpassSelect = 3'd6;
        for (int i = 1; i <= 20; i++) begin
            step();
            want = (i <= 3) ? 4'hE : 4'hF;
            checks++;
            if (leds_n !== exp_leds || leds_n[11:8] !== want) begin
                errors++;
                $display("FAIL lp_invalid cyc %0d got %h exp %h", i, leds_n[11:8], want);
            end
        end
        lowpassSelect = 3'd1;
        for (int i = 1; i <= 24; i++) begin
            step();
            if (i <= 3) want = 4'hF;
            else if (i < 20 && ((i - 4) / 4) % 2 == 0) want = 4'hF;
            else want = 4'hD;
            checks++;
            if (leds_n !== exp_leds || leds_n[11:8] !== want) begin
                errors++;
                $display("FAIL lp_recover cyc %0d got %h exp %h", i, leds_n[11:8], want);
            end
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        freqSelect = 3'd0;
        highpassSelect = 3'd3;
        for (int i = 1; i <= 24; i++) begin
            step();
            checks++;
            if (leds_n !== exp_leds || (i >= 4 && leds_n[0] !== leds_n[15])) begin
                errors++;
                $display("FAIL simultaneous cyc %0d got %h exp %h", i, leds_n, exp_leds);
            end
        end
        checks++;
        if (leds_n !== 16'h7EFE) begin
            errors++;
            $display("FAIL simultaneous_final got %h exp 7efe", leds_n);
        end
    endtask

    task automatic test_restart();
        logic [7:0] want;
        do_reset();
        freqSelect = 3'd1;
        for (int i = 1; i <= 5; i++) begin
            step();
            checks++;
            if (leds_n !== exp_leds) begin
                errors++;
                $display("FAIL restart_first cyc %0d got %h exp %h", i, leds_n, exp_leds);
            end
        end
        freqSelect = 3'd7;
        for (int i = 1; i <= 24; i++) begin
            step();
            if (i >= 4 && i < 20) want = (((i - 4) / 4) % 2 == 0) ? 8'hFF : 8'h7F;
            else want = exp_leds[7:0];
            checks++;
            if (leds_n !== exp_leds || leds_n[7:0] !== want || (i >= 20 && leds_n[7:0] !== 8'h7F)) begin
                errors++;
                $display("FAIL restart_second cyc %0d got %h exp %h", i, leds_n, exp_leds);
            end
        end
    endtask

    task automatic test_reset_mid_blink();
        freqSelect = 3'd3;
        for (int i = 1; i <= 6; i++) step();
        do_reset();
        step();
        checks++;
        if (leds_n !== 16'hEEDF) begin
            errors++;
            $display("FAIL reset_mid_blink got %h exp eedf", leds_n);
        end
    endtask

    task automatic test_dimming();
        int lows [3];
        do_reset();
        lows[0] = 0;
        lows[1] = 0;
        lows[2] = 0;
        for (int i = 1; i <= 32; i++) begin
            step();
            lows[0] += leds_n_dim[5] ? 0 : 1;
            lows[1] += leds_n_dim[8] ? 0 : 1;
            lows[2] += leds_n_dim[12] ? 0 : 1;
            checks++;
            if (leds_n_dim !== exp_dim || (leds_n_dim | 16'h1120) !== 16'hFFFF) begin
                errors++;
                $display("FAIL dimming cyc %0d got %h exp %h", i, leds_n_dim, exp_dim);
            end
        end
        checks++;
        if (lows[0] != 8 || lows[1] != 8 || lows[2] != 8) begin
            errors++;
            $display("FAIL dimming_count got %0d %0d %0d exp 8 8 8", lows[0], lows[1], lows[2]);
        end
    endtask

    task automatic test_random();
        int hold;
        for (int s = 0; s < 150; s++) begin
            freqSelect = 3'($urandom_range(0, 7));
            lowpassSelect = 3'($urandom_range(0, 7));
            highpassSelect = 3'($urandom_range(0, 7));
            hold = $urandom_range(1, 25);
            for (int i = 0; i < hold; i++) begin
                step();
                checks++;
                if (leds_n !== exp_leds || leds_n_dim !== exp_dim) begin
                    errors++;
                    $display("FAIL random seg %0d got %h/%h exp %h/%h", s, leds_n, leds_n_dim,
                             exp_leds, exp_dim);
                end
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_freq_change();
        test_invalid_lowpass();
        test_simultaneous();
        test_restart();
        test_reset_mid_blink();
        test_dimming();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/select_led_driver.md
# select_led_driver

Indicator driver for the channel-strip front panel: takes the 3-bit frequency, lowpass and highpass selection codes produced by the button encoder and drives the 16 active-low panel LEDs that sit next to the buttons. It uses the same bit mapping as the buttons. The block synchronizes the selection codes into the system clock domain and lights one LED per group. It also flashes a group's LED when that group's selection changes, and applies global PWM dimming.

## Interface
- BLINK_HALF_CYCLES, 6250000: clock cycles per blink phase (OFF or ON); must be ≥1.
- BLINK_COUNT, 3: number of OFF/ON pairs per change notification; must be ≥1.
- PWM_BITS, 4: width of the free-running dimming counter.
- DUTY, 15: lit LEDs are driven low when pwm_cnt ≤ DUTY; 2**PWM_BITS-1 means always on.
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- freqSelect  input  3  frequency selection 0..7; asynchronous to clk.
- lowpassSelect  input  3  lowpass selection 0..3; 4..7 is invalid; asynchronous.
- highpassSelect  input  3  highpass selection 0..3; 4..7 is invalid; asynchronous.
- leds_n  output  16  registered, active-low LED drive.
  - bits 7:0 = freq 0..7.
  - bits 11:8 = lowpass 0..3.
  - bits 15:12 = highpass 0..3.

## Operation
- **Synchronizer:** a 2-flop synchronizer covers all 9 select bits. Its stage-2 output is copied into "accepted" registers (acc_f, acc_lp, acc_hp) every cycle.
- **Change detection:** each group compares the stage-2 value with its current accepted value. Any inequality is a change event for that group.
- **Blink FSM:** one independent FSM per group (3 total), with states IDLE and BLINK.
  - On a change event in any state: load phase_cnt = BLINK_HALF_CYCLES-1, pair_cnt = BLINK_COUNT-1, phase = OFF, and go to BLINK.
  - A change during BLINK restarts the sequence with the new value.
  - In BLINK, phase_cnt decrements every cycle. At 0 it reloads and the phase toggles OFF→ON or ON→OFF.
  - On the ON→OFF toggle: if pair_cnt = 0, go to IDLE; otherwise decrement pair_cnt.
  - Total BLINK duration is 2·BLINK_COUNT·BLINK_HALF_CYCLES cycles, then steady lit.
- **Group LED decode:**
  - The LED of the accepted value is lit when the group is IDLE, or in BLINK with phase ON.
  - All LEDs of the group are dark in phase OFF.
  - Non-selected LEDs are always dark.
- **Invalid lowpass/highpass (4..7):**
  - All 4 LEDs of the group stay dark.
  - A change into an invalid value sets the FSM to IDLE, not BLINK.
  - A change from invalid to valid blinks normally.
- **Dimming:** pwm_cnt is a PWM_BITS-wide counter that increments every cycle and wraps. A lit LED drives leds_n low only when pwm_cnt ≤ DUTY. Dark LEDs are always high.
- **Simultaneous events:** changes in several groups on the same cycle each start their own FSM; there is no arbitration.
- **Reset (async, any time, including mid-blink):**
  - Synchronizer and accepted registers → f=5, lp=0, hp=0 (the encoder's reset code).
  - All FSMs → IDLE; phase_cnt, pair_cnt and pwm_cnt → 0.
  - leds_n → 16'hFFFF.
  - No blink is triggered on reset release.

## Timing
- leds_n is fully registered.
- Input stable before edge 1:
  - edge 1: sync stage 1.
  - edge 2: stage 2.
  - edge 3: accepted register and FSM update.
  - edge 4: leds_n reflects the change.
  - Latency is 4 clk edges.
- First edge after reset release (DUTY max): leds_n = 16'hEEDF, i.e. bits 5, 8 and 12 low.
- A multi-bit skew in the asynchronous inputs may produce a one-cycle intermediate accepted value. That value triggers a blink that restarts on the next cycle; this is acceptable.
- Blink phase boundaries land exactly every BLINK_HALF_CYCLES edges after the edge-4 OFF phase begins.

## Test plan
Parameters BLINK_HALF_CYCLES=4, BLINK_COUNT=2, DUTY=15 unless stated.

- **Reset:** assert reset, then release with f=5, lp=0, hp=0 → leds_n=16'hFFFF during reset; 16'hEEDF from the first edge after release, with no blink.
- **Frequency change:** freqSelect 5→2 → leds_n[7:0]=8'hFF from edge 4 for 4 cycles, then 8'hFB ×4, 8'hFF ×4, then 8'hFB steady. Bits 15:8 unchanged.
- **Invalid lowpass:** lowpassSelect→6 → leds_n[11:8]=4'hF steady, no blink. Then →1 → leds_n[11:8] pattern F,D,F,D in 4-cycle phases, then 4'hD steady.
- **Simultaneous change:** freq→0 and highpass→3 on the same cycle → bit 0 and bit 15 blink in lockstep. Final leds_n = 16'h7EFE.
- **Restart and reset mid-blink:**
  - freq→1, then freq→7 two cycles into the OFF phase → blink restarts, with 16 cycles of blinking measured from the second change.
  - Reset mid-blink → immediate 16'hFFFF, then 16'hEEDF on release.
- **Dimming:** DUTY=3, PWM_BITS=4, idle → each lit bit is low for exactly 4 of every 16 cycles (pwm_cnt 0..3); dark bits are always high.
